// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared types and constants for the interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  // Register offsets within the four-register window
  localparam logic [1:0] OFS_PENDING = 2'd0;
  localparam logic [1:0] OFS_MASK    = 2'd1;
  localparam logic [1:0] OFS_ACTIVE  = 2'd2;
  localparam logic [1:0] OFS_CLEAR   = 2'd3;

  // Value of grant_id / ACTIVE_ID when nothing is granted
  localparam logic [7:0] NO_ID = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/irq_priority_arbiter.sv
// ============================================================================
// Module      : irq_priority_arbiter
// Description : Combinational priority arbiter. Searches the eligible vector
//               starting at the priority pointer and wrapping around; the
//               first set bit found wins. A pointer of 0 gives fixed
//               lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_priority_arbiter
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] i_eligible,
  input  logic [7:0]         i_pointer,
  output logic [7:0]         o_winner,
  output logic               o_valid
);

  // Scan from the farthest offset back to the pointer so the nearest hit wins
  always_comb begin : p_arb
    int idx;
    idx      = 0;
    o_winner = NO_ID;
    o_valid  = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(i_pointer) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      if ((idx < NUM_SRC) && i_eligible[idx]) begin
        o_winner = 8'(idx);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module      : irq_controller
// Description : Memory-mapped interrupt controller. Captures rising edges of
//               per-source IRQ lines into a pending register, masks them,
//               arbitrates, raises CPU_IRQ and returns a one-cycle ack to the
//               granted source when the CPU acknowledges.
//               Optional feature macro: IRQ_CTRL_ROUND_ROBIN_EN selects
//               rotating priority; undefined gives fixed lowest-index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter logic [7:0] p_base_addr    = 8'hE8,
  parameter int         p_num_src      = 4,
  parameter logic [7:0] p_initial_mask = 8'hFF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [7:0]           BUS_DATA,
  input  logic [7:0]           BUS_ADDR,
  input  logic                 BUS_WE,
  input  logic [p_num_src-1:0] SRC_IRQ_RAISE,
  output logic [p_num_src-1:0] SRC_IRQ_ACK,
  output logic                 CPU_IRQ,
  input  logic                 CPU_IRQ_ACK
);

  state_t               r_state;
  logic [p_num_src-1:0] r_src_q;
  logic [p_num_src-1:0] r_pending;
  logic [7:0]           r_mask;
  logic [7:0]           r_grant_id;
  logic                 r_cpu_irq;
  logic [p_num_src-1:0] r_src_ack;
  logic                 r_rd_en;
  logic [7:0]           r_rd_data;

  logic [7:0]           w_offset;
  logic                 w_hit;
  logic                 w_wr_mask;
  logic                 w_wr_clear;
  logic [p_num_src-1:0] w_rise;
  logic [p_num_src-1:0] w_eligible;
  logic [p_num_src-1:0] w_grant_onehot;
  logic [p_num_src-1:0] w_clear;
  logic [7:0]           w_pending8;
  logic [7:0]           w_rd_mux;
  logic [7:0]           w_ptr;
  logic [7:0]           w_arb_winner;
  logic                 w_arb_valid;

  // Address decode works for any base, aligned or not
  assign w_offset   = BUS_ADDR - p_base_addr;
  assign w_hit      = (w_offset < 8'd4);
  assign w_wr_mask  = w_hit && BUS_WE && (w_offset[1:0] == OFS_MASK);
  assign w_wr_clear = w_hit && BUS_WE && (w_offset[1:0] == OFS_CLEAR);

  assign w_rise     = SRC_IRQ_RAISE & ~r_src_q;
  assign w_eligible = r_pending & r_mask[p_num_src-1:0];

  // One-hot decode of the current grant, used for the ack pulse and pending clear
  always_comb begin
    w_grant_onehot = '0;
    for (int i = 0; i < p_num_src; i++) begin
      w_grant_onehot[i] = (r_grant_id == 8'(i));
    end
  end

  // Pending bits cleared by the ACK state or a CLEAR write
  always_comb begin
    w_clear = '0;
    if (r_state == ST_ACK) begin
      w_clear = w_clear | w_grant_onehot;
    end
    if (w_wr_clear) begin
      w_clear = w_clear | BUS_DATA[p_num_src-1:0];
    end
  end

  // Read-data mux; pending is zero-extended to the bus width
  always_comb begin
    w_pending8                = '0;
    w_pending8[p_num_src-1:0] = r_pending;
    case (w_offset[1:0])
      OFS_PENDING: w_rd_mux = w_pending8;
      OFS_MASK:    w_rd_mux = r_mask;
      OFS_ACTIVE:  w_rd_mux = r_grant_id;
      default:     w_rd_mux = 8'h00;
    endcase
  end

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [7:0] r_rr_ptr;

  // Priority pointer advances past the source just acknowledged
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rr_ptr <= 8'h00;
    end else if (r_state == ST_ACK) begin
      if ((r_grant_id + 8'd1) >= 8'(p_num_src)) begin
        r_rr_ptr <= 8'h00;
      end else begin
        r_rr_ptr <= r_grant_id + 8'd1;
      end
    end
  end

  assign w_ptr = r_rr_ptr;
`else
  assign w_ptr = 8'h00;
`endif

  irq_priority_arbiter #(
    .NUM_SRC    (p_num_src)
  ) u_arbiter (
    .i_eligible (w_eligible),
    .i_pointer  (w_ptr),
    .o_winner   (w_arb_winner),
    .o_valid    (w_arb_valid)
  );

  // Edge capture and pending update; a new edge wins over a same-cycle clear
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_src_q   <= '0;
      r_pending <= '0;
    end else begin
      r_src_q   <= SRC_IRQ_RAISE;
      r_pending <= (r_pending & ~w_clear) | w_rise;
    end
  end

  // Mask register write
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mask <= p_initial_mask;
    end else if (w_wr_mask) begin
      r_mask <= BUS_DATA;
    end
  end

  // Registered read path: data is presented the cycle after the address
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_en   <= 1'b0;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_en   <= w_hit && !BUS_WE && (w_offset[1:0] != OFS_CLEAR);
      r_rd_data <= w_rd_mux;
    end
  end

  // Grant FSM with registered CPU_IRQ and SRC_IRQ_ACK
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_grant_id <= NO_ID;
      r_cpu_irq  <= 1'b0;
      r_src_ack  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_grant_id <= w_arb_winner;
            r_cpu_irq  <= 1'b1;
            r_state    <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (CPU_IRQ_ACK) begin
            r_cpu_irq <= 1'b0;
            r_src_ack <= w_grant_onehot;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_src_ack  <= '0;
          r_grant_id <= NO_ID;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_cpu_irq  <= 1'b0;
          r_src_ack  <= '0;
          r_grant_id <= NO_ID;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUS_DATA    = r_rd_en ? r_rd_data : 8'hZZ;
  assign CPU_IRQ     = r_cpu_irq;
  assign SRC_IRQ_ACK = r_src_ack;

endmodule

`default_nettype wire
